// File: rtl/id_ex_stage.sv
// Decode/issue register ahead of the ALU: builds {opcode,funct} control, extends imm, 1-entry skid.
// Optional operand forwarding at accept time is enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
   parameter int W  = 32,
   parameter int CW = 12
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [W-1:0]  instr_i,
   input  logic [W-1:0]  rs_data_i,
   input  logic [W-1:0]  rt_data_i,
   input  logic          flush_i,
`ifdef ID_EX_FWD_EN
   input  logic          fwd_valid_i,
   input  logic [4:0]    fwd_reg_i,
   input  logic [W-1:0]  fwd_data_i,
`endif
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [CW-1:0] cnt_o,
   output logic [W-1:0]  rs_o,
   output logic [W-1:0]  rt_o,
   output logic [W-1:0]  imm_o,
   output logic [4:0]    dst_o
);

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic [W-1:0]  rs;
      logic [W-1:0]  rt;
      logic [W-1:0]  imm;
      logic [4:0]    dst;
   } uop_t;

   logic [5:0] op, fn;
   uop_t       dec;
   uop_t       out_q, out_d, skid_q, skid_d;
   logic       out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic       accept;

   assign op = instr_i[31:26];
   assign fn = instr_i[5:0];

   always_comb begin
      dec    = '0;
      dec.rs = rs_data_i;
      dec.rt = rt_data_i;
      if (op == 6'd0) begin
         dec.cnt = CW'({6'd0, fn});
         dec.dst = instr_i[15:11];
      end else begin
         dec.cnt = CW'({op, 6'd0});
         dec.dst = (op == 6'd40) ? 5'd0 : instr_i[20:16];
      end
      // Unknown opcodes fall through with imm=0; the ALU treats them as no-ops.
      case (op)
         6'd8, 6'd32, 6'd40: dec.imm = {{(W-16){instr_i[15]}}, instr_i[15:0]};
         6'd12, 6'd13:       dec.imm = {{(W-16){1'b0}}, instr_i[15:0]};
         default:            dec.imm = '0;
      endcase
`ifdef ID_EX_FWD_EN
      if (fwd_valid_i && fwd_reg_i != 5'd0 && fwd_reg_i == instr_i[25:21]) dec.rs = fwd_data_i;
      if (fwd_valid_i && fwd_reg_i != 5'd0 && fwd_reg_i == instr_i[20:16]) dec.rt = fwd_data_i;
`endif
   end

`ifndef ID_EX_FWD_EN
   logic unused_rs_field;
   assign unused_rs_field = ^instr_i[25:21];
`endif

   assign accept = in_valid_i && !skid_vld_q && !flush_i;

   // Skid entry is always older than new input, so it drains before anything is accepted.
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush_i) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         if (out_ready_i) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_vld_q || out_ready_i) begin
            out_d     = dec;
            out_vld_d = 1'b1;
         end else begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
         end
      end else if (out_ready_i) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign in_ready_o  = !skid_vld_q;
   assign out_valid_o = out_vld_q;
   assign cnt_o       = out_q.cnt;
   assign rs_o        = out_q.rs;
   assign rt_o        = out_q.rt;
   assign imm_o       = out_q.imm;
   assign dst_o       = out_q.dst;

endmodule
